next_pc_ctrl: RTL and testbench
===============================

NEXT_PC_CTRL -- requirements
Module: next_pc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h00400000, NextPC value driven while Reset is high.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h80000180, exception handler address.
REQ-004 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port PC  input  WIDTH  current PC from the program counter register.
REQ-007 SHALL have port Stall  input  1  holds PC and all state.
REQ-008 SHALL have port Branch  input  1  conditional branch decoded.
REQ-009 SHALL have port Zero  input  1  branch condition true.
REQ-010 SHALL have port BranchOffset  input  16  signed word offset.
REQ-011 SHALL have port Jump  input  1  direct jump decoded.
REQ-012 SHALL have port JumpIndex  input  26  jump word index.
REQ-013 SHALL have port JumpReg  input  1  register-indirect jump decoded.
REQ-014 SHALL have port RegTarget  input  WIDTH  register jump target.
REQ-015 SHALL have port Exception  input  1  exception request, one cycle.
REQ-016 SHALL have port NextPC  output  WIDTH  next PC to the program counter register.
REQ-017 SHALL have port InDelaySlot  output  1  high while the state is SLOT.
REQ-018 SHALL have port EPC  output  WIDTH  registered exception return address.
REQ-019 SHALL have port ExcBD  output  1  registered; exception taken in a delay slot.

Function
REQ-020 SHALL compute NextPC combinationally from inputs and registered state, with zero-cycle latency.
REQ-021 SHALL compute PC+4 modulo 2^WIDTH (0xFFFFFFFC+4 = 0x00000000).
REQ-022 SHALL form targets as: branch = PC+4 + (sext(BranchOffset)<<2); jump = {PC+4[31:28], JumpIndex, 2'b00}; register = RegTarget, unmodified.
REQ-023 SHALL treat a redirect as JumpReg, Jump, or (Branch and Zero), with priority JumpReg > Jump > Branch.
REQ-024 SHALL select NextPC with priority Reset > Exception > Stall > redirect > sequential.
REQ-025 SHALL implement two states, SEQ and SLOT.
REQ-026 In SEQ with no event, SHALL drive NextPC = PC+4.
REQ-027 On Stall, SHALL drive NextPC = PC and hold state, PendingTarget, EPC and ExcBD.
REQ-028 On Exception in SEQ, SHALL drive NextPC = EXC_VECTOR and register EPC <= PC and ExcBD <= 0.
REQ-029 On Exception in SLOT, SHALL drive NextPC = EXC_VECTOR, register EPC <= PC-4 and ExcBD <= 1, discard PendingTarget, and go to SEQ.
REQ-030 Exception SHALL override Stall.
REQ-031 In SLOT without Stall or Exception, SHALL drive NextPC = PendingTarget, go to SEQ, and ignore any redirect inputs.
REQ-032 In SLOT with Stall, SHALL remain in SLOT.

Reset
REQ-033 While Reset is high, SHALL drive NextPC = RESET_PC regardless of other inputs.
REQ-034 On a rising edge with Reset high, SHALL set state = SEQ, PendingTarget = 0, EPC = 0 and ExcBD = 0; InDelaySlot then reads 0.
REQ-035 Reset asserted in SLOT SHALL discard the pending target.

Configuration
REQ-036 SHALL compile the branch delay slot in when macro NEXT_PC_DELAY_SLOT_EN is defined.
REQ-037 With NEXT_PC_DELAY_SLOT_EN defined, a redirect in SEQ SHALL drive NextPC = PC+4, register PendingTarget <= target, and go to SLOT.
REQ-038 Without NEXT_PC_DELAY_SLOT_EN, a redirect SHALL drive NextPC = target directly; the state SHALL stay SEQ, InDelaySlot and ExcBD SHALL stay 0, and EPC SHALL always equal the faulting PC.

Verification
REQ-039 Reset=1, PC=0x12345678 -> NextPC=0x00400000; after the edge, InDelaySlot=0 and EPC=0.
REQ-040 PC=0x00400000, Branch=1, Zero=1, BranchOffset=0xFFFF with DELAY_SLOT_EN defined -> NextPC=0x00400004; next cycle, PC=0x00400004 -> NextPC=0x00400000 and InDelaySlot=1. Without the macro -> NextPC=0x00400000 immediately.
REQ-041 PC=0x00400010, Jump=1, JumpReg=1, RegTarget=0x00400100 -> target 0x00400100 (JumpReg wins); with Stall=1 instead -> NextPC=0x00400010 and state held.
REQ-042 In SLOT with PC=0x00400008 and Exception=1 -> NextPC=0x80000180, EPC=0x00400004, ExcBD=1; then state SEQ.
REQ-043 PC=0xFFFFFFFC, no event -> NextPC=0x00000000. Exception plus Stall in SEQ with PC=0x00400020 -> NextPC=0x80000180, EPC=0x00400020.

Source files
------------

// File: rtl/next_pc_ctrl.sv
// next_pc_ctrl -- next-PC selection for a MIPS-style fetch stage.
//
// NextPC is combinational (zero-cycle latency) from the inputs and a small
// amount of registered state. Selection priority:
//   Reset > Exception > Stall > pending delay-slot target > redirect > PC+4
// Redirect priority: JumpReg > Jump > (Branch & Zero).
//
// Optional feature: define NEXT_PC_DELAY_SLOT_EN to build in one
// architectural branch delay slot. A redirect then fetches PC+4 first,
// records the target, and enters SLOT. The next non-stalled cycle issues
// the recorded target. Without the macro, redirects take effect immediately
// and the SLOT state is never entered.
//
// Parameters:
//   WIDTH      address width (at least 29 for the jump target form)
//   RESET_PC   NextPC value while Reset is high
//   EXC_VECTOR exception handler address
// Ports:
//   Clk          rising-edge clock
//   Reset        synchronous, active-high reset
//   PC           current PC from the program counter register
//   Stall        hold PC and all state
//   Branch/Zero  conditional branch decoded / condition true
//   BranchOffset signed word offset
//   Jump         direct jump decoded; JumpIndex gives the word index
//   JumpReg      register-indirect jump decoded; RegTarget gives the target
//   Exception    one-cycle exception request
//   NextPC       next PC to the program counter register
//   InDelaySlot  high while in the SLOT state
//   EPC          registered exception return address
//   ExcBD        registered; exception was taken in a delay slot

module next_pc_ctrl #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h00400000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h80000180
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] PC,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             Zero,
    input  logic [15:0]      BranchOffset,
    input  logic             Jump,
    input  logic [25:0]      JumpIndex,
    input  logic             JumpReg,
    input  logic [WIDTH-1:0] RegTarget,
    input  logic             Exception,
    output logic [WIDTH-1:0] NextPC,
    output logic             InDelaySlot,
    output logic [WIDTH-1:0] EPC,
    output logic             ExcBD
);

    typedef enum logic {
        SEQ,
        SLOT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending_target;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] epc_next;
    logic             exc_bd_next;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] redirect_target;
    logic             redirect;

    assign pc_plus4      = PC + WIDTH'(4);
    // Sign-extended word offset, already scaled by 4.
    assign branch_target = pc_plus4 + {{(WIDTH-18){BranchOffset[15]}}, BranchOffset, 2'b00};
    assign jump_target   = {pc_plus4[WIDTH-1:28], JumpIndex, 2'b00};
    assign redirect      = JumpReg | Jump | (Branch & Zero);

    always_comb begin
        redirect_target = branch_target;
        if (JumpReg) begin
            redirect_target = RegTarget;
        end else if (Jump) begin
            redirect_target = jump_target;
        end
    end

    assign InDelaySlot = (state == SLOT);

    always_comb begin
        NextPC       = pc_plus4;
        state_next   = state;
        pending_next = pending_target;
        epc_next     = EPC;
        exc_bd_next  = ExcBD;

        if (Reset) begin
            // Registered state is cleared by the synchronous reset itself.
            NextPC = RESET_PC;
        end else if (Exception) begin
            NextPC       = EXC_VECTOR;
            state_next   = SEQ;
            pending_next = '0;
            // In SLOT the faulting instruction is the delay slot; return to
            // the redirecting instruction one word earlier.
            epc_next     = (state == SLOT) ? (PC - WIDTH'(4)) : PC;
            exc_bd_next  = (state == SLOT);
        end else if (Stall) begin
            NextPC = PC;
        end else if (state == SLOT) begin
            // Redirect inputs are ignored while the slot retires.
            NextPC     = pending_target;
            state_next = SEQ;
        end else if (redirect) begin
`ifdef NEXT_PC_DELAY_SLOT_EN
            NextPC       = pc_plus4;
            pending_next = redirect_target;
            state_next   = SLOT;
`else
            NextPC = redirect_target;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= SEQ;
            pending_target <= '0;
            EPC            <= '0;
            ExcBD          <= 1'b0;
        end else begin
            state          <= state_next;
            pending_target <= pending_next;
            EPC            <= epc_next;
            ExcBD          <= exc_bd_next;
        end
    end

endmodule

// File: tb/tb_next_pc_ctrl.sv
// tb_next_pc_ctrl -- self-checking bench for next_pc_ctrl.
//
// A behavioural model tracks the expected NextPC and registered outputs;
// the delay slot is modelled as a queue of pending targets. One negedge
// process compares the DUT against the model every cycle. Directed cases
// pin the model to hand-computed values, then a randomized run follows.
// Honours NEXT_PC_DELAY_SLOT_EN the same way as the design.

module tb_next_pc_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PC;
    logic        Stall;
    logic        Branch;
    logic        Zero;
    logic [15:0] BranchOffset;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic        JumpReg;
    logic [31:0] RegTarget;
    logic        Exception;
    logic [31:0] NextPC;
    logic        InDelaySlot;
    logic [31:0] EPC;
    logic        ExcBD;

    next_pc_ctrl #(
        .WIDTH(32),
        .RESET_PC(32'h00400000),
        .EXC_VECTOR(32'h80000180)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .PC(PC),
        .Stall(Stall),
        .Branch(Branch),
        .Zero(Zero),
        .BranchOffset(BranchOffset),
        .Jump(Jump),
        .JumpIndex(JumpIndex),
        .JumpReg(JumpReg),
        .RegTarget(RegTarget),
        .Exception(Exception),
        .NextPC(NextPC),
        .InDelaySlot(InDelaySlot),
        .EPC(EPC),
        .ExcBD(ExcBD)
    );

    initial forever #5 Clk = ~Clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_en = 1'b0;
    bit          regs_valid = 1'b0;

    // Model: current and next-cycle values.
    logic [31:0] exp_npc = '0;
    logic [31:0] m_q[$];
    logic [31:0] n_q[$];
    logic [31:0] m_epc = '0;
    logic [31:0] n_epc = '0;
    logic        m_excbd = 1'b0;
    logic        n_excbd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected behaviour for the inputs currently applied.
    task automatic eval();
        logic [31:0] pc4;
        logic [31:0] tgt;
        int          off_i;
        bit          in_slot;
        pc4     = PC + 32'd4;
        off_i   = $signed(BranchOffset);
        in_slot = (m_q.size() != 0);
        n_q     = m_q;
        n_epc   = m_epc;
        n_excbd = m_excbd;
        if (JumpReg)   tgt = RegTarget;
        else if (Jump) tgt = {pc4[31:28], JumpIndex, 2'b00};
        else           tgt = pc4 + 32'(off_i * 4);

        if (Reset) begin
            exp_npc = 32'h00400000;
            n_q.delete();
            n_epc   = '0;
            n_excbd = 1'b0;
        end else if (Exception) begin
            exp_npc = 32'h80000180;
            n_epc   = in_slot ? PC - 32'd4 : PC;
            n_excbd = in_slot;
            n_q.delete();
        end else if (Stall) begin
            exp_npc = PC;
        end else if (in_slot) begin
            exp_npc = n_q.pop_front();
        end else if (JumpReg || Jump || (Branch && Zero)) begin
`ifdef NEXT_PC_DELAY_SLOT_EN
            exp_npc = pc4;
            n_q.push_back(tgt);
`else
            exp_npc = tgt;
`endif
        end else begin
            exp_npc = pc4;
        end
    endtask

    task automatic advance();
        @(posedge Clk);
        m_q     = n_q;
        m_epc   = n_epc;
        m_excbd = n_excbd;
        if (Reset) regs_valid = 1'b1;
        #1;
    endtask

    task automatic idle();
        Reset        = 1'b0;
        Stall        = 1'b0;
        Branch       = 1'b0;
        Zero         = 1'b0;
        BranchOffset = '0;
        Jump         = 1'b0;
        JumpIndex    = '0;
        JumpReg      = 1'b0;
        RegTarget    = '0;
        Exception    = 1'b0;
    endtask

    function automatic logic [31:0] slot_flag();
        return {31'b0, (m_q.size() != 0)};
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("next_pc", NextPC, exp_npc);
            if (regs_valid) begin
                chk("in_delay_slot", {31'b0, InDelaySlot}, slot_flag());
                chk("epc", EPC, m_epc);
                chk("exc_bd", {31'b0, ExcBD}, {31'b0, m_excbd});
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [31:0] prev;
        idle();
        PC = '0;
        @(posedge Clk);
        #1;

        // Reset overrides every other input.
        Reset = 1'b1; PC = 32'h12345678; Stall = 1'b1; Exception = 1'b1;
        Branch = 1'b1; Zero = 1'b1; Jump = 1'b1;
        chk_en = 1'b1;
        eval();
        chk("pin_reset_npc", exp_npc, 32'h00400000);
        advance();
        chk("pin_reset_epc", m_epc, 32'h0);

        // Branch back by one word.
        idle(); PC = 32'h00400000; Branch = 1'b1; Zero = 1'b1; BranchOffset = 16'hFFFF;
        eval();
`ifdef NEXT_PC_DELAY_SLOT_EN
        chk("pin_branch_npc", exp_npc, 32'h00400004);
`else
        chk("pin_branch_npc", exp_npc, 32'h00400000);
`endif
        advance();
        idle(); PC = 32'h00400004;
        eval();
`ifdef NEXT_PC_DELAY_SLOT_EN
        chk("pin_slot_npc", exp_npc, 32'h00400000);
        chk("pin_slot_flag", slot_flag(), 32'h1);
`endif
        advance();

        // Exception in the delay slot.
        idle(); PC = 32'h00400004; Branch = 1'b1; Zero = 1'b1; BranchOffset = 16'h0010;
        eval(); advance();
        idle(); PC = 32'h00400008; Exception = 1'b1; Jump = 1'b1;
        eval();
        chk("pin_exc_npc", exp_npc, 32'h80000180);
        advance();
`ifdef NEXT_PC_DELAY_SLOT_EN
        chk("pin_exc_epc", m_epc, 32'h00400004);
        chk("pin_exc_bd", {31'b0, m_excbd}, 32'h1);
`else
        chk("pin_exc_epc", m_epc, 32'h00400008);
        chk("pin_exc_bd", {31'b0, m_excbd}, 32'h0);
`endif
        chk("pin_exc_seq", slot_flag(), 32'h0);

        // JumpReg beats Jump.
        idle(); PC = 32'h00400010; Jump = 1'b1; JumpReg = 1'b1;
        JumpIndex = 26'h0000123; RegTarget = 32'h00400100;
        eval();
`ifdef NEXT_PC_DELAY_SLOT_EN
        chk("pin_jr_npc", exp_npc, 32'h00400014);
        advance();
        idle(); PC = 32'h00400014;
        eval();
        chk("pin_jr_target", exp_npc, 32'h00400100);
`else
        chk("pin_jr_npc", exp_npc, 32'h00400100);
`endif
        advance();

        // Stall holds PC and state.
        idle(); PC = 32'h00400010; Jump = 1'b1; JumpReg = 1'b1;
        RegTarget = 32'h00400100; Stall = 1'b1;
        eval();
        chk("pin_stall_npc", exp_npc, 32'h00400010);
        advance();
        chk("pin_stall_seq", slot_flag(), 32'h0);

        // Stall while in the slot keeps the pending target.
        idle(); PC = 32'h00400010; Branch = 1'b1; Zero = 1'b1; BranchOffset = 16'h0004;
        eval(); advance();
`ifdef NEXT_PC_DELAY_SLOT_EN
        idle(); PC = 32'h00400014; Stall = 1'b1;
        eval();
        chk("pin_slot_stall_npc", exp_npc, 32'h00400014);
        advance();
        chk("pin_slot_stall_flag", slot_flag(), 32'h1);
        idle(); PC = 32'h00400014;
        eval();
        chk("pin_slot_release", exp_npc, 32'h00400024);
        advance();
`endif

        // PC+4 wraps.
        idle(); PC = 32'hFFFFFFFC;
        eval();
        chk("pin_wrap_npc", exp_npc, 32'h00000000);
        advance();

        // Exception overrides Stall.
        idle(); PC = 32'h00400020; Exception = 1'b1; Stall = 1'b1;
        eval();
        chk("pin_exc_stall_npc", exp_npc, 32'h80000180);
        advance();
        chk("pin_exc_stall_epc", m_epc, 32'h00400020);

        // Reset in the slot discards the pending target.
        idle(); PC = 32'h00400000; Jump = 1'b1; JumpIndex = 26'h0000040;
        eval(); advance();
        idle(); Reset = 1'b1; PC = 32'h00400004;
        eval(); advance();
        chk("pin_reset_slot", slot_flag(), 32'h0);
        idle(); PC = 32'h00400000;
        eval();
        chk("pin_after_reset", exp_npc, 32'h00400004);
        advance();

        // Randomized run; PC mostly follows the expected NextPC.
        for (int i = 0; i < 3000; i++) begin
            prev = exp_npc;
            idle();
            r = $urandom();
            PC           = ($urandom_range(0, 9) < 7) ? prev : (r & 32'hFFFFFFFC);
            Reset        = ($urandom_range(0, 59) == 0);
            Exception    = ($urandom_range(0, 19) == 0);
            Stall        = ($urandom_range(0, 6) == 0);
            Branch       = ($urandom_range(0, 2) == 0);
            Zero         = $urandom_range(0, 1) != 0;
            BranchOffset = 16'($urandom());
            Jump         = ($urandom_range(0, 9) == 0);
            JumpIndex    = 26'($urandom());
            JumpReg      = ($urandom_range(0, 9) == 0);
            RegTarget    = $urandom();
            eval();
            advance();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
